// File: rtl/demux_1x4_pkg.sv
// Shared definitions for the 1-to-4 registered demultiplexer:
// default widths, channel index constants and the select decode helper.
package demux_1x4_pkg;

  // Default data width of the input stream and of every output channel.
  localparam int WIDTH_DEF = 64;

  // Default width of each per-channel delivered-word counter.
  localparam int CNT_W_DEF = 16;

  // Number of output channels.
  localparam int NUM_CH = 4;

  // Channel indices as carried on the select field.
  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2,
    CH3 = 2'd3
  } ch_e;

  // One-hot decode of a channel index (bit N set for channel N).
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1x4_if.sv
// Bus bundle for demux_1x4: the tagged input stream, the four output
// channels with their handshakes, the debug counters and the busy flag.
interface demux_1x4_if
  import demux_1x4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  // Input stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       select;

  // Output channels
  logic             o0_valid;
  logic             o1_valid;
  logic             o2_valid;
  logic             o3_valid;
  logic             o0_ready;
  logic             o1_ready;
  logic             o2_ready;
  logic             o3_ready;
  logic [WIDTH-1:0] o0_data;
  logic [WIDTH-1:0] o1_data;
  logic [WIDTH-1:0] o2_data;
  logic [WIDTH-1:0] o3_data;

  // Debug and status
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;
  logic             busy;

  // Environment side: producer of the input stream and consumer of the channels.
  modport master (
    output in_valid, in_data, select,
    output o0_ready, o1_ready, o2_ready, o3_ready,
    input  in_ready,
    input  o0_valid, o1_valid, o2_valid, o3_valid,
    input  o0_data, o1_data, o2_data, o3_data,
    input  cnt0, cnt1, cnt2, cnt3, busy
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_data, select,
    input  o0_ready, o1_ready, o2_ready, o3_ready,
    output in_ready,
    output o0_valid, o1_valid, o2_valid, o3_valid,
    output o0_data, o1_data, o2_data, o3_data,
    output cnt0, cnt1, cnt2, cnt3, busy
  );

endinterface

// File: rtl/demux_1x4_slot.sv
// One output channel of demux_1x4: a single-entry holding register with
// valid/ready output handshake plus a wrapping count of loaded words.
module demux_slot
  import demux_1x4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Slot occupancy: a load wins over a drain so a same-cycle drain+load keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Slot contents: only a load changes them, so data is held after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
    end else if (load) begin
      data_p1 <= in_data;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (load) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign cnt       = cnt_p1;

endmodule

// File: rtl/demux_1x4.sv
// 1-to-4 registered demultiplexer. Each word of the tagged input stream is
// steered to the channel named by select and held there in a one-entry slot.
// Only the addressed slot gates in_ready, so a stalled channel never blocks
// traffic bound for the others.
module demux_1x4
  import demux_1x4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  demux_1x4_if.slave bus
);

  logic [NUM_CH-1:0] slot_vld;
  logic [NUM_CH-1:0] slot_rdy;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt  [NUM_CH];
  logic              ready_sel;
  logic              accept;

  assign slot_rdy = {bus.o3_ready, bus.o2_ready, bus.o1_ready, bus.o0_ready};

  // in_ready mux: the addressed slot can take a word if empty or draining this cycle.
  always_comb begin
    ready_sel = 1'b0;
    case (ch_e'(bus.select))
      CH0:     ready_sel = !slot_vld[0] | slot_rdy[0];
      CH1:     ready_sel = !slot_vld[1] | slot_rdy[1];
      CH2:     ready_sel = !slot_vld[2] | slot_rdy[2];
      CH3:     ready_sel = !slot_vld[3] | slot_rdy[3];
      default: ready_sel = 1'b0;
    endcase
  end

  assign bus.in_ready = ready_sel;
  assign accept       = bus.in_valid & ready_sel;

  // Select decode: at most one slot loads per cycle.
  always_comb begin
    load = '0;
    if (accept) begin
      load = ch_onehot(bus.select);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[n]),
      .in_data   (bus.in_data),
      .out_ready (slot_rdy[n]),
      .out_valid (slot_vld[n]),
      .out_data  (slot_data[n]),
      .cnt       (slot_cnt[n])
    );
  end

  assign bus.o0_valid = slot_vld[0];
  assign bus.o1_valid = slot_vld[1];
  assign bus.o2_valid = slot_vld[2];
  assign bus.o3_valid = slot_vld[3];

  assign bus.o0_data  = slot_data[0];
  assign bus.o1_data  = slot_data[1];
  assign bus.o2_data  = slot_data[2];
  assign bus.o3_data  = slot_data[3];

  assign bus.cnt0     = slot_cnt[0];
  assign bus.cnt1     = slot_cnt[1];
  assign bus.cnt2     = slot_cnt[2];
  assign bus.cnt3     = slot_cnt[3];

  // busy comes from slot registers only, never from inputs.
  assign bus.busy     = |slot_vld;

endmodule

// File: tb/tb_demux_1x4.sv
// Directed bench for demux_1x4: reset, routing, throughput, non-blocking
// behaviour, counter wrap and asynchronous mid-operation reset.
module tb_demux_1x4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  demux_1x4_if bus ();

  demux_1x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with a word presented: nothing may be captured.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.select   = 2'd2;
    bus.in_data  = 64'h1234;
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    bus.o2_ready = 1'b0;
    bus.o3_ready = 1'b0;
    step();
    step();
    check("rst_o0_valid", 64'(bus.o0_valid), 64'd0);
    check("rst_o2_valid", 64'(bus.o2_valid), 64'd0);
    check("rst_cnt2", 64'(bus.cnt2), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_o2_data", bus.o2_data, 64'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single route to channel 1 with its consumer stalled.
    bus.in_data  = 64'hDEAD_BEEF_0000_0001;
    bus.select   = 2'd1;
    bus.in_valid = 1'b1;
    step();
    check("route_o1_valid", 64'(bus.o1_valid), 64'd1);
    check("route_o1_data", bus.o1_data, 64'hDEAD_BEEF_0000_0001);
    check("route_cnt1", 64'(bus.cnt1), 64'd1);
    check("route_o0_valid", 64'(bus.o0_valid), 64'd0);
    check("route_o2_valid", 64'(bus.o2_valid), 64'd0);
    check("route_o3_valid", 64'(bus.o3_valid), 64'd0);
    check("route_busy", 64'(bus.busy), 64'd1);
    bus.in_data = 64'hBAD0;
    #1;
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("full_o1_data_held", bus.o1_data, 64'hDEAD_BEEF_0000_0001);
    check("full_cnt1_held", 64'(bus.cnt1), 64'd1);
    check("full_o1_valid_held", 64'(bus.o1_valid), 64'd1);
    bus.in_valid = 1'b0;

    // Back-to-back words to channel 2 with its consumer always ready.
    bus.o2_ready = 1'b1;
    bus.select   = 2'd2;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 64'(i);
      #1;
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      check("b2b_o2_valid", 64'(bus.o2_valid), 64'd1);
      check("b2b_o2_data", bus.o2_data, 64'(i));
    end
    bus.in_valid = 1'b0;
    check("b2b_cnt2", 64'(bus.cnt2), 64'd4);
    step();
    check("drain_o2_valid", 64'(bus.o2_valid), 64'd0);
    check("drain_o2_data_held", bus.o2_data, 64'd4);
    bus.o2_ready = 1'b0;

    // Channel 0 full and stalled must not block channel 3.
    bus.select   = 2'd0;
    bus.in_data  = 64'hA0;
    bus.in_valid = 1'b1;
    step();
    check("nb_o0_valid", 64'(bus.o0_valid), 64'd1);
    #1;
    check("nb_ch0_in_ready", 64'(bus.in_ready), 64'd0);
    bus.select  = 2'd3;
    bus.in_data = 64'h55;
    #1;
    check("nb_ch3_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("nb_o3_valid", 64'(bus.o3_valid), 64'd1);
    check("nb_o3_data", bus.o3_data, 64'h55);
    check("nb_o0_data_held", bus.o0_data, 64'hA0);
    check("nb_o0_valid_held", 64'(bus.o0_valid), 64'd1);

    // Counter wrap on channel 0: cnt0 is 1, 65534 more accepts reach 0xFFFF.
    bus.o0_ready = 1'b1;
    bus.select   = 2'd0;
    bus.in_data  = 64'h1111;
    bus.in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("wrap_cnt0_max", 64'(bus.cnt0), 64'hFFFF);
    bus.in_data = 64'hCAFE;
    step();
    check("wrap_cnt0_zero", 64'(bus.cnt0), 64'd0);
    check("wrap_o0_data", bus.o0_data, 64'hCAFE);
    check("wrap_o0_valid", 64'(bus.o0_valid), 64'd1);
    bus.in_valid = 1'b0;
    bus.o0_ready = 1'b0;
    step();
    check("wrap_o0_stalled", 64'(bus.o0_valid), 64'd1);

    // Fill channel 2 so all four slots hold a word.
    bus.select   = 2'd2;
    bus.in_data  = 64'h77;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("full4_o2_valid", 64'(bus.o2_valid), 64'd1);
    check("full4_o1_valid", 64'(bus.o1_valid), 64'd1);
    check("full4_o3_valid", 64'(bus.o3_valid), 64'd1);

    // Asynchronous reset between edges clears everything immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o0_valid", 64'(bus.o0_valid), 64'd0);
    check("arst_o1_valid", 64'(bus.o1_valid), 64'd0);
    check("arst_o2_valid", 64'(bus.o2_valid), 64'd0);
    check("arst_o3_valid", 64'(bus.o3_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_cnt1", 64'(bus.cnt1), 64'd0);
    check("arst_cnt2", 64'(bus.cnt2), 64'd0);
    check("arst_o1_data", bus.o1_data, 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check("post_arst_busy", 64'(bus.busy), 64'd0);
    check("post_arst_o3_valid", 64'(bus.o3_valid), 64'd0);
    check("post_arst_cnt0", 64'(bus.cnt0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1x4.md
Name: demux_1x4

Overview:
- 64-bit 1-to-4 registered demultiplexer; the distribution end of the 4-way datapath select path.
- Takes one valid/ready input stream tagged with a 2-bit select and delivers each word to exactly one of four output channels.
- Each channel has a one-entry holding slot, so a stalled channel does not block words for other channels.
- Maintains per-channel delivered-word counters for datapath debug.

Parameters:
- WIDTH, 64, data width of input and each output channel.
- CNT_W, 16, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word addressed by select.
- in_data  input  WIDTH  input word.
- select  input  2  destination channel, 0..3.
- o0_valid, o1_valid, o2_valid, o3_valid  output  1 each  channel slot holds a word.
- o0_ready, o1_ready, o2_ready, o3_ready  input  1 each  channel consumer takes the word.
- o0_data, o1_data, o2_data, o3_data  output  WIDTH each  channel slot contents.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  words accepted per channel.
- busy  output  1  OR of all oN_valid.

Behaviour:
- Reset (async assert on rst_n=0, sync release): all oN_valid=0, oN_data=0, cntN=0, busy=0.
- in_ready is combinational: in_ready = !oS_valid | oS_ready, where S = select.
- in_ready depends only on the selected channel; other channels never gate it.
- Accept occurs when in_valid & in_ready at a rising clk edge.
- On accept: slot S loads in_data, oS_valid=1 next cycle, and cntS increments.
- Latency is 1 cycle from accept to oS_valid; no combinational path from in_data to oN_data.
- A channel drains when oN_valid & oN_ready. On drain with no accept to that channel, oN_valid clears next cycle.
- oN_data holds its last value after drain; it is not zeroed.
- Drain and accept on the same channel in the same cycle: oN_valid stays 1 and oN_data takes the new word. This gives full throughput of 1 word/cycle per channel.
- Full channel with oN_ready=0: in_ready=0 for that select. Holding data and valid are unchanged, and the counter does not increment.
- in_valid=0: no state change except drains.
- select may change every cycle; only its value at the accept edge matters.
- There is no requirement that select be stable while in_ready=0, and the upstream may retarget to another channel.
- No word is ever dropped or duplicated. Each accepted word appears exactly once on exactly one channel, in per-channel acceptance order.
- Counters wrap modulo 2^CNT_W (0xFFFF+1 -> 0x0000) with no saturation and no flag.
- oN_valid/oN_data must stay stable while oN_valid & !oN_ready. Any violation is an RTL bug.
- Reset asserted mid-operation clears all slots and counters immediately. Held words are discarded, and in_ready reflects empty slots (1) while reset is active.
- busy = o0_valid | o1_valid | o2_valid | o3_valid, registered-derived, no input dependency.

Decomposition:
- Shared include file demux_defs.vh holds: WIDTH default 64, CNT_W default 16, channel index constants CH0..CH3 = 2'd0..2'd3.
- Sub-module demux_slot: one-entry holding register plus counter for one channel.
  - Ports: clk, rst_n, load, in_data, out_ready, out_valid, out_data, cnt.
  - It is instantiated four times.
- The top level contains:
  - the 2-to-4 select decode producing load = in_valid & in_ready & (select==N);
  - the in_ready mux over the four slots;
  - the busy OR.

Test Plan:
- Reset: rst_n=0 with in_valid=1, select=2 -> all oN_valid=0, cntN=0, busy=0. After release, in_ready=1.
- Single route: in_data=64'hDEAD_BEEF_0000_0001, select=1, o1_ready=0 -> next cycle o1_valid=1 with that data, cnt1=1, and the other channels stay invalid. A second word to select=1 then sees in_ready=0.
- Back-to-back fill/drain: o2_ready=1 held, four words 1,2,3,4 to select=2 on consecutive cycles -> in_ready=1 every cycle, o2_data sequence 1,2,3,4 one cycle delayed, cnt2=4.
- Non-blocking: channel 0 full and stalled (o0_ready=0), then word 64'h55 to select=3 -> in_ready=1, accepted, o3_valid=1 next cycle. o0_data is unchanged.
- Wrap: preload cnt0 to 16'hFFFF via 65535 accepts, then one more -> cnt0=16'h0000, and the word is delivered.
- Mid-operation reset: all four slots full, pulse rst_n=0 asynchronously between edges -> all valid drop immediately, counters become 0, and no held word appears after release.
